uart_imem_loader: RTL and testbench
===================================

Name: uart_imem_loader

Overview:
- Drives the CPU rather than observing it: a UART boot loader that receives a program image serially and writes it into instruction memory.
- Holds the CPU in reset while the image loads, then releases it.
- Sits in the top level between the board UART RX pin, the instruction-memory write port and the CPU `rst` input.
- Replaces preloading the memory image at simulation or synthesis time.

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz.
- BAUD, 115200, UART bit rate. BIT_TICKS = CLK_FREQ/BAUD, integer division, must be ≥ 4.
- ADDR_W, 6, instruction-memory word-address width. Maximum image is 2^ADDR_W words.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-low reset (0 = reset).
- uart_rx  in  1  asynchronous serial input, 8N1, idle high.
- imem_we  out  1  one-cycle instruction-memory write strobe.
- imem_addr  out  ADDR_W  word address of the write.
- imem_wdata  out  32  instruction word.
- cpu_rst  out  1  active-low reset to the CPU: 0 while loading, 1 after a successful load.
- busy  out  1  high from count-byte start bit until done or error.
- done  out  1  sticky, high after a successful load.
- err  out  1  sticky, high on framing, count or checksum error.

Behaviour:
- Reset (rst=0 at a clk edge):
  - outputs: imem_we=0, imem_addr=0, imem_wdata=0, cpu_rst=0, busy=0, done=0, err=0.
  - internal: FSM to IDLE; byte/word counters and the RX sampler cleared.
  - A mid-load reset aborts and discards the partial word. Words already written are not retracted.
- RX path:
  - uart_rx passes through a 2-FF synchronizer.
  - A start bit is a falling edge detected while the sampler is idle. It is re-checked at BIT_TICKS/2; if high, treat as a glitch and return to idle.
  - Data bits are sampled every BIT_TICKS after that midpoint, LSB first.
  - The stop bit is sampled at its midpoint. Stop = 0 is a framing error.
  - The byte-valid pulse lasts one cycle, in the cycle after the stop sample.
- FSM states: IDLE, COUNT, DATA, CHECK (feature only), RUN, ERROR.
  - IDLE→COUNT: first start bit; busy goes 1.
  - COUNT: the first byte is N, the word count. N=0 or N>2^ADDR_W → ERROR. Otherwise → DATA.
  - DATA: bytes assemble little-endian (byte0 = bits 7:0).
    - On the 4th byte: imem_wdata and imem_addr are valid and imem_we=1 for exactly one cycle, the cycle after that byte's valid pulse.
    - imem_addr increments after each write, starting at 0.
    - Address wrap cannot occur (N is bounded).
  - After word N: → RUN (or CHECK with the feature).
  - RUN: cpu_rst=1, done=1, busy=0. All further RX bytes are ignored. Leaving RUN requires rst.
  - ERROR: err=1, busy=0, cpu_rst stays 0, imem_we never asserts. Leaving ERROR requires rst.
- Any framing error in COUNT/DATA/CHECK → ERROR.
- Latency: cpu_rst rises the cycle after the final imem_we pulse, or the cycle after a checksum pass.
- imem_we=0 and the address/data hold their last values whenever not writing.

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- Defined:
  - After N words, one extra byte is received. It must equal the XOR of all 4N data bytes (count byte excluded).
  - Match → RUN.
  - Mismatch → ERROR.
  - Words were already written; cpu_rst stays 0.
- Undefined: CHECK state and XOR register absent; DATA goes directly to RUN.

Decomposition:
- Package loader_pkg:
  - state enum typedef (IDLE, COUNT, DATA, CHECK, RUN, ERROR).
  - 8-bit byte typedef.
  - constant function computing BIT_TICKS and the counter width from CLK_FREQ/BAUD.
- Sub-module uart_rx_byte:
  - synchronizer, baud counter, bit shifter.
  - outputs rx_data[7:0], rx_valid (1-cycle pulse), rx_ferr (1-cycle pulse).
- The top level holds the FSM, byte assembly, counters and the optional checksum.

Test Plan:
Bench uses CLK_FREQ=1000000, BAUD=100000 (10 clocks/bit) and ADDR_W=6.
- Reset then idle line for 200 cycles → all outputs 0, busy=0, no imem_we.
- Send N=0x02 then bytes 13 05 A0 00 93 05 F0 FF → imem_we pulses twice: addr 0 data 0x00A00513, addr 1 data 0xFFF00593. cpu_rst=1 and done=1 the cycle after the 2nd pulse.
- Send N=0x00 → err=1, cpu_rst=0, no imem_we. Repeat with N=0x41 → same result.
- Send N=0x01, then a data byte with stop bit forced 0 → err=1, no writes, cpu_rst stays 0.
- Drop rst to 0 after 2 of 4 data bytes, release, send a full N=1 image 78 56 34 12 → single write, addr 0 data 0x12345678, then RUN.
- LOADER_CHECKSUM_EN defined:
  - N=1, bytes 78 56 34 12, checksum 0x08 → RUN.
  - Same image with checksum 0x09 → one write occurs, then err=1 and cpu_rst=0.

Source files
------------

// File: rtl/loader_pkg.sv
// Shared types and baud-rate helpers for the UART instruction-memory boot loader.
package loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COUNT,
        ST_DATA,
        ST_CHECK,
        ST_RUN,
        ST_ERROR
    } state_e;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

    typedef logic [7:0] byte_t;

    function automatic int bit_ticks(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

    // Counter only has to reach BIT_TICKS-1.
    function automatic int tick_cnt_w(input int clk_freq, input int baud);
        int w;
        w = $clog2(clk_freq / baud);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: 2-FF synchronizer, mid-bit sampling, one-cycle valid / framing-error pulses.
module uart_rx_byte
    import loader_pkg::*;
#(
    parameter int CLK_FREQ = 50000000,
    parameter int BAUD     = 115200
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  rx_in,
    output byte_t rx_data,
    output logic  rx_start,
    output logic  rx_valid,
    output logic  rx_ferr
);

    localparam int BT = bit_ticks(CLK_FREQ, BAUD);
    localparam int CW = tick_cnt_w(CLK_FREQ, BAUD);
    localparam logic [CW-1:0] HALF_LAST = CW'(BT / 2 - 1);
    localparam logic [CW-1:0] FULL_LAST = CW'(BT - 1);

    logic          sync1_q, sync2_q, prev_q;
    rx_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    byte_t         shift_q, shift_d;
    logic          start_q, start_d, valid_q, valid_d, ferr_q, ferr_d;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        start_d = 1'b0;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            RX_IDLE: begin
                cnt_d = '0;
                if (prev_q && !sync2_q) state_d = RX_START;
            end
            RX_START: if (cnt_q == HALF_LAST) begin
                cnt_d = '0;
                bit_d = '0;
                if (sync2_q) begin
                    state_d = RX_IDLE;
                end else begin
                    state_d = RX_DATA;
                    start_d = 1'b1;
                end
            end
            RX_DATA: if (cnt_q == FULL_LAST) begin
                cnt_d   = '0;
                shift_d = {sync2_q, shift_q[7:1]};
                if (bit_q == 3'd7) state_d = RX_STOP;
                else               bit_d   = bit_q + 1'b1;
            end
            RX_STOP: if (cnt_q == FULL_LAST) begin
                state_d = RX_IDLE;
                valid_d = sync2_q;
                ferr_d  = !sync2_q;
            end
            default: state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses <= so every flop samples the pre-edge values.
        if (!rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            start_q <= 1'b0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            sync1_q <= rx_in;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            start_q <= start_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    assign rx_data  = shift_q;
    assign rx_start = start_q;
    assign rx_valid = valid_q;
    assign rx_ferr  = ferr_q;

endmodule

// File: rtl/uart_imem_loader.sv
// UART boot loader: receives a word count and a little-endian image, writes it to IMEM, then releases the CPU.
// Define LOADER_CHECKSUM_EN to require a trailing XOR checksum byte before the CPU is released.
module uart_imem_loader
    import loader_pkg::*;
#(
    parameter int CLK_FREQ = 50000000,
    parameter int BAUD     = 115200,
    parameter int ADDR_W   = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              uart_rx,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_rst,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int WL_W      = ADDR_W + 1;
    localparam int MAX_WORDS = 1 << ADDR_W;

    byte_t rx_data;
    logic  rx_start, rx_valid, rx_ferr;

    uart_rx_byte #(
        .CLK_FREQ(CLK_FREQ),
        .BAUD    (BAUD)
    ) u_rx (
        .clk     (clk),
        .rst     (rst),
        .rx_in   (uart_rx),
        .rx_data (rx_data),
        .rx_start(rx_start),
        .rx_valid(rx_valid),
        .rx_ferr (rx_ferr)
    );

    state_e            state_q, state_d;
    logic [1:0]        byte_idx_q, byte_idx_d;
    logic [23:0]       word_q, word_d;
    logic [WL_W-1:0]   words_left_q, words_left_d;
    logic [ADDR_W-1:0] next_addr_q, next_addr_d;
    logic              imem_we_q, imem_we_d;
    logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
    logic [31:0]       imem_wdata_q, imem_wdata_d;
`ifdef LOADER_CHECKSUM_EN
    byte_t             chk_q, chk_d;
`endif

    always_comb begin
        state_d      = state_q;
        byte_idx_d   = byte_idx_q;
        word_d       = word_q;
        words_left_d = words_left_q;
        next_addr_d  = next_addr_q;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
`ifdef LOADER_CHECKSUM_EN
        chk_d        = chk_q;
`endif
        case (state_q)
            ST_IDLE: if (rx_start) state_d = ST_COUNT;
            ST_COUNT: begin
                if (rx_ferr) begin
                    state_d = ST_ERROR;
                end else if (rx_valid) begin
                    if (rx_data == '0 || int'(rx_data) > MAX_WORDS) begin
                        state_d = ST_ERROR;
                    end else begin
                        state_d      = ST_DATA;
                        words_left_d = WL_W'(rx_data);
                    end
                end
            end
            ST_DATA: begin
                if (rx_ferr) begin
                    state_d = ST_ERROR;
                end else if (rx_valid) begin
`ifdef LOADER_CHECKSUM_EN
                    chk_d = chk_q ^ rx_data;
`endif
                    byte_idx_d = byte_idx_q + 1'b1;
                    if (byte_idx_q == 2'd3) begin
                        imem_we_d    = 1'b1;
                        imem_addr_d  = next_addr_q;
                        imem_wdata_d = {rx_data, word_q};
                        next_addr_d  = next_addr_q + 1'b1;
                        words_left_d = words_left_q - 1'b1;
                    end else begin
                        word_d = {rx_data, word_q[23:8]};
                    end
                end else if (imem_we_q && words_left_q == '0) begin
                    // Leave only once the final write strobe has been presented.
`ifdef LOADER_CHECKSUM_EN
                    state_d = ST_CHECK;
`else
                    state_d = ST_RUN;
`endif
                end
            end
`ifdef LOADER_CHECKSUM_EN
            ST_CHECK: begin
                if (rx_ferr)       state_d = ST_ERROR;
                else if (rx_valid) state_d = (rx_data == chk_q) ? ST_RUN : ST_ERROR;
            end
`endif
            ST_RUN, ST_ERROR: ;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            byte_idx_q   <= '0;
            word_q       <= '0;
            words_left_q <= '0;
            next_addr_q  <= '0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
`ifdef LOADER_CHECKSUM_EN
            chk_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            byte_idx_q   <= byte_idx_d;
            word_q       <= word_d;
            words_left_q <= words_left_d;
            next_addr_q  <= next_addr_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
`ifdef LOADER_CHECKSUM_EN
            chk_q        <= chk_d;
`endif
        end
    end

    assign imem_we    = imem_we_q;
    assign imem_addr  = imem_addr_q;
    assign imem_wdata = imem_wdata_q;
    assign cpu_rst    = (state_q == ST_RUN);
    assign done       = (state_q == ST_RUN);
    assign err        = (state_q == ST_ERROR);
    assign busy       = (state_q == ST_COUNT) || (state_q == ST_DATA) || (state_q == ST_CHECK);

endmodule

// File: tb/tb_uart_imem_loader.sv
// Bench for uart_imem_loader: serial images against a byte-level reference model of the load protocol.
`timescale 1ns/1ps
module tb_uart_imem_loader;

    localparam int CLK_FREQ = 1000000;
    localparam int BAUD     = 100000;
    localparam int ADDR_W   = 6;
    localparam int BT       = CLK_FREQ / BAUD;
    localparam int MAX_N    = 1 << ADDR_W;

    typedef logic [7:0] byte_q_t[$];
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              uart_rx = 1'b1;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              cpu_rst, busy, done, err;

    int  errors = 0;
    int  checks = 0;
    wr_t wr_q[$];
    int  cyc = 0;
    int  last_we_cyc = -1;
    int  rise_cyc = -1;
    bit  we_long = 1'b0;
    bit  prev_we = 1'b0;
    bit  prev_cpu = 1'b0;

    always #5 clk = ~clk;

    uart_imem_loader #(
        .CLK_FREQ(CLK_FREQ),
        .BAUD    (BAUD),
        .ADDR_W  (ADDR_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .uart_rx   (uart_rx),
        .imem_we   (imem_we),
        .imem_addr (imem_addr),
        .imem_wdata(imem_wdata),
        .cpu_rst   (cpu_rst),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    // Write/strobe logger, sampled on the falling edge.
    always @(negedge clk) begin
        cyc++;
        if (imem_we === 1'b1) begin
            wr_q.push_back({imem_addr, imem_wdata});
            last_we_cyc = cyc;
            if (prev_we) we_long = 1'b1;
        end
        if (cpu_rst === 1'b1 && !prev_cpu) rise_cyc = cyc;
        prev_we  = (imem_we === 1'b1);
        prev_cpu = (cpu_rst === 1'b1);
    end

    task automatic clear_log();
        wr_q.delete();
        last_we_cyc = -1;
        rise_cyc    = -1;
        we_long     = 1'b0;
    endtask

    task automatic apply_reset();
        uart_rx = 1'b1;
        rst     = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        clear_log();
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop);
        @(negedge clk);
        uart_rx = 1'b0;
        repeat (BT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (BT) @(negedge clk);
        end
        uart_rx = stop;
        repeat (BT) @(negedge clk);
        uart_rx = 1'b1;
        repeat (BT) @(negedge clk);
    endtask

    function automatic byte_q_t with_chk(input byte_q_t s);
        byte_q_t r;
        r = s;
`ifdef LOADER_CHECKSUM_EN
        begin
            logic [7:0] x;
            x = 8'h00;
            for (int i = 1; i < s.size(); i++) x ^= s[i];
            r.push_back(x);
        end
`endif
        return r;
    endfunction

    // Protocol-level reference: which words get written and whether the load ends in RUN.
    function automatic void model(input byte_q_t s, input int ferr_at,
                                  output wr_t exp[$], output bit exp_run);
        int n;
        exp     = {};
        exp_run = 1'b0;
        if (ferr_at == 0) return;
        n = int'(s[0]);
        if (n == 0 || n > MAX_N) return;
        for (int w = 0; w < n; w++) begin
            if (ferr_at >= 1 && ferr_at <= 4 * w + 4) return;
            exp.push_back({ADDR_W'(w), s[4*w+4], s[4*w+3], s[4*w+2], s[4*w+1]});
        end
`ifdef LOADER_CHECKSUM_EN
        begin
            logic [7:0] x;
            x = 8'h00;
            for (int i = 1; i <= 4 * n; i++) x ^= s[i];
            if (ferr_at == 4 * n + 1) return;
            exp_run = (s[4*n+1] == x);
        end
`else
        exp_run = 1'b1;
`endif
    endfunction

    task automatic run_image(input byte_q_t s, input int ferr_at, input bit do_reset, input string name);
        wr_t exp[$];
        bit  exp_run;
        bit  exp_busy;
        int  waited;
        if (do_reset) apply_reset();
        for (int i = 0; i < s.size(); i++) begin
            send_byte(s[i], i != ferr_at);
            if (i == 0) begin
                exp_busy = (ferr_at != 0) && (int'(s[0]) != 0) && (int'(s[0]) <= MAX_N);
                checks++;
                if (busy !== exp_busy) begin
                    errors++;
                    $display("FAIL %s busy_after_count: got %b want %b", name, busy, exp_busy);
                end
            end
            if (i == ferr_at) break;
        end
        waited = 0;
        while (!(done === 1'b1 || err === 1'b1) && waited < 400) begin
            @(negedge clk);
            waited++;
        end
        repeat (5) @(negedge clk);
        model(s, ferr_at, exp, exp_run);
        checks++;
        if (!(done === 1'b1 || err === 1'b1)) begin
            errors++;
            $display("FAIL %s timeout: done=%b err=%b after %0d cycles", name, done, err, waited);
        end
        checks++;
        if (wr_q.size() != exp.size()) begin
            errors++;
            $display("FAIL %s write_count: got %0d want %0d", name, wr_q.size(), exp.size());
        end else begin
            foreach (exp[i]) begin
                checks++;
                if (wr_q[i] !== exp[i]) begin
                    errors++;
                    $display("FAIL %s write[%0d]: got addr %0d data %h want addr %0d data %h",
                             name, i, wr_q[i].addr, wr_q[i].data, exp[i].addr, exp[i].data);
                end
            end
        end
        checks++;
        if ({done, err, cpu_rst, busy} !== {exp_run, !exp_run, exp_run, 1'b0}) begin
            errors++;
            $display("FAIL %s status: got done=%b err=%b cpu_rst=%b busy=%b want done=%b err=%b cpu_rst=%b busy=0",
                     name, done, err, cpu_rst, busy, exp_run, !exp_run, exp_run);
        end
        checks++;
        if (we_long) begin
            errors++;
            $display("FAIL %s we_width: got strobe longer than 1 cycle want 1 cycle", name);
        end
`ifndef LOADER_CHECKSUM_EN
        if (exp_run) begin
            checks++;
            if (rise_cyc != last_we_cyc + 1) begin
                errors++;
                $display("FAIL %s cpu_rst_latency: got rise at %0d want %0d", name, rise_cyc, last_we_cyc + 1);
            end
        end
`endif
    endtask

    task automatic test_reset();
        uart_rx = 1'b1;
        rst     = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({imem_we, imem_addr, imem_wdata, cpu_rst, busy, done, err} !== '0) begin
            errors++;
            $display("FAIL reset_hold: got we=%b addr=%0d data=%h cpu_rst=%b busy=%b done=%b err=%b want all 0",
                     imem_we, imem_addr, imem_wdata, cpu_rst, busy, done, err);
        end
        rst = 1'b1;
        clear_log();
        repeat (200) @(negedge clk);
        checks++;
        if ({imem_we, imem_addr, imem_wdata, cpu_rst, busy, done, err} !== '0) begin
            errors++;
            $display("FAIL reset_idle: got we=%b addr=%0d data=%h cpu_rst=%b busy=%b done=%b err=%b want all 0",
                     imem_we, imem_addr, imem_wdata, cpu_rst, busy, done, err);
        end
        checks++;
        if (wr_q.size() != 0) begin
            errors++;
            $display("FAIL reset_no_write: got %0d writes want 0", wr_q.size());
        end
    endtask

    task automatic test_spec_image();
        byte_q_t s;
        s = {8'h02, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'hF0, 8'hFF};
        run_image(with_chk(s), -1, 1'b1, "spec_image");
        checks++;
        if (wr_q.size() != 2 || wr_q[0] !== {6'd0, 32'h00A00513} || wr_q[1] !== {6'd1, 32'hFFF00593}) begin
            errors++;
            $display("FAIL spec_image_words: got %0d writes want addr0=00a00513 addr1=fff00593", wr_q.size());
        end
        for (int i = 0; i < 5; i++) send_byte(8'($urandom), 1'b1);
        repeat (5) @(negedge clk);
        checks++;
        if (wr_q.size() != 2 || done !== 1'b1 || cpu_rst !== 1'b1) begin
            errors++;
            $display("FAIL run_ignores_rx: got writes=%0d done=%b cpu_rst=%b want 2 1 1", wr_q.size(), done, cpu_rst);
        end
    endtask

    task automatic test_bad_count();
        byte_q_t s;
        s = {8'h00};
        run_image(s, -1, 1'b1, "count_zero");
        s = {8'h41};
        run_image(s, -1, 1'b1, "count_over");
        s = {8'($urandom_range(8'h42, 8'hFF))};
        run_image(s, -1, 1'b1, "count_rand_over");
    endtask

    task automatic test_framing();
        byte_q_t s;
        s = {8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
        run_image(with_chk(s), 1, 1'b1, "framing_data");
        run_image(with_chk(s), 0, 1'b1, "framing_count");
    endtask

    task automatic test_mid_reset();
        byte_q_t s;
        apply_reset();
        send_byte(8'h01, 1'b1);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (wr_q.size() != 0 || busy !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_abort: got writes=%0d busy=%b err=%b want 0 0 0", wr_q.size(), busy, err);
        end
        s = {8'h01, 8'h78, 8'h56, 8'h34, 8'h12};
        run_image(with_chk(s), -1, 1'b0, "mid_reset_reload");
    endtask

    task automatic test_random_images();
        byte_q_t s;
        int      n;
        int      ferr_at;
        for (int it = 0; it < 7; it++) begin
            n = (it == 6) ? MAX_N : int'($urandom_range(1, 5));
            s = {8'(n)};
            for (int i = 0; i < 4 * n; i++) s.push_back(8'($urandom));
            s = with_chk(s);
            ferr_at = (it < 6 && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4 * n)) : -1;
            run_image(s, ferr_at, 1'b1, $sformatf("random_%0d", it));
        end
    endtask

`ifdef LOADER_CHECKSUM_EN
    task automatic test_checksum();
        byte_q_t s;
        s = {8'h01, 8'h78, 8'h56, 8'h34, 8'h12, 8'h08};
        run_image(s, -1, 1'b1, "checksum_good");
        s = {8'h01, 8'h78, 8'h56, 8'h34, 8'h12, 8'h09};
        run_image(s, -1, 1'b1, "checksum_bad");
        s = {8'h01, 8'h78, 8'h56, 8'h34, 8'h12, 8'h08};
        run_image(s, 5, 1'b1, "checksum_framing");
    endtask
`endif

    initial begin
        test_reset();
        test_spec_image();
        test_bad_count();
        test_framing();
        test_mid_reset();
        test_random_images();
`ifdef LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
